// File: rtl/midi_msg_parser_if.sv
// Byte-in / message-out bundle for the MIDI message parser.
// The slave side is the parser; the master side feeds bytes and observes results.
interface midi_msg_parser_if;
  logic       byte_valid;
  logic [7:0] byte_in;
  logic       byte_ferr;

  logic       msg_valid;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;
  logic [1:0] msg_len;

  logic       rt_valid;
  logic [7:0] rt_byte;

  logic       sysex_active;
  logic [7:0] frame_err_cnt;

  modport master (
    output byte_valid, byte_in, byte_ferr,
    input  msg_valid, msg_status, msg_data1, msg_data2, msg_len,
    input  rt_valid, rt_byte, sysex_active, frame_err_cnt
  );

  modport slave (
    input  byte_valid, byte_in, byte_ferr,
    output msg_valid, msg_status, msg_data1, msg_data2, msg_len,
    output rt_valid, rt_byte, sysex_active, frame_err_cnt
  );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-to-message parser: assembles channel-voice and system-common
// messages with running status, passes realtime bytes through immediately,
// swallows SysEx payloads and counts framing errors.
module midi_msg_parser #(
  parameter bit RUNNING_STATUS_EN = 1'b1,
  parameter bit VEL0_NOTEOFF      = 1'b1
) (
  input logic               clk,
  input logic               reset_n,
  midi_msg_parser_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StVoice  = 2'd1,
    StCommon = 2'd2,
    StSysex  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] status_q, status_d;
  logic [1:0] need_q, need_d;
  logic [1:0] idx_q, idx_d;
  logic [6:0] data1_q, data1_d;

  logic       msg_valid_q, msg_valid_d;
  logic [7:0] msg_status_q, msg_status_d;
  logic [6:0] msg_data1_q, msg_data1_d;
  logic [6:0] msg_data2_q, msg_data2_d;
  logic [1:0] msg_len_q, msg_len_d;
  logic       rt_valid_q, rt_valid_d;
  logic [7:0] rt_byte_q, rt_byte_d;
  logic [7:0] ferr_cnt_q, ferr_cnt_d;

  logic       is_note_off_v0;

  // Note-on with velocity 0 completing on this byte is re-labelled as note-off.
  assign is_note_off_v0 = VEL0_NOTEOFF && (status_q[7:4] == 4'h9) &&
                          (bus.byte_in[6:0] == 7'd0);

  // Next-state decode: framing errors first, then realtime, status, data.
  always_comb begin
    state_d      = state_q;
    status_d     = status_q;
    need_d       = need_q;
    idx_d        = idx_q;
    data1_d      = data1_q;
    msg_valid_d  = 1'b0;
    msg_status_d = msg_status_q;
    msg_data1_d  = msg_data1_q;
    msg_data2_d  = msg_data2_q;
    msg_len_d    = msg_len_q;
    rt_valid_d   = 1'b0;
    rt_byte_d    = rt_byte_q;
    ferr_cnt_d   = ferr_cnt_q;

    if (bus.byte_valid) begin
      if (bus.byte_ferr) begin
        // Corrupt byte: drop it and restart data collection, keep status.
        idx_d = 2'd0;
        if (ferr_cnt_q != 8'hFF) ferr_cnt_d = ferr_cnt_q + 8'd1;
      end else if (bus.byte_in >= 8'hF8) begin
        // Realtime bytes never disturb the message in progress.
        rt_valid_d = 1'b1;
        rt_byte_d  = bus.byte_in;
      end else if (bus.byte_in[7]) begin
        idx_d    = 2'd0;
        status_d = bus.byte_in;
        case (bus.byte_in[7:4])
          4'h8, 4'h9, 4'hA, 4'hB, 4'hE: begin
            need_d  = 2'd2;
            state_d = StVoice;
          end
          4'hC, 4'hD: begin
            need_d  = 2'd1;
            state_d = StVoice;
          end
          default: begin
            case (bus.byte_in[3:0])
              4'h1, 4'h3: begin
                need_d  = 2'd1;
                state_d = StCommon;
              end
              4'h2: begin
                need_d  = 2'd2;
                state_d = StCommon;
              end
              4'h6: begin
                msg_valid_d  = 1'b1;
                msg_status_d = bus.byte_in;
                msg_data1_d  = 7'd0;
                msg_data2_d  = 7'd0;
                msg_len_d    = 2'd0;
                state_d      = StIdle;
              end
              4'h0:    state_d = StSysex;
              default: state_d = StIdle;
            endcase
          end
        endcase
      end else if (state_q == StVoice || state_q == StCommon) begin
        if (idx_q == 2'd0 && need_q == 2'd2) begin
          data1_d = bus.byte_in[6:0];
          idx_d   = 2'd1;
        end else begin
          msg_valid_d  = 1'b1;
          msg_status_d = status_q;
          msg_len_d    = need_q;
          idx_d        = 2'd0;
          if (need_q == 2'd1) begin
            msg_data1_d = bus.byte_in[6:0];
            msg_data2_d = 7'd0;
          end else begin
            msg_data1_d = data1_q;
            msg_data2_d = bus.byte_in[6:0];
            if (is_note_off_v0) msg_status_d = {4'h8, status_q[3:0]};
          end
          if (state_q == StCommon || !RUNNING_STATUS_EN) state_d = StIdle;
        end
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      status_q     <= 8'd0;
      need_q       <= 2'd0;
      idx_q        <= 2'd0;
      data1_q      <= 7'd0;
      msg_valid_q  <= 1'b0;
      msg_status_q <= 8'd0;
      msg_data1_q  <= 7'd0;
      msg_data2_q  <= 7'd0;
      msg_len_q    <= 2'd0;
      rt_valid_q   <= 1'b0;
      rt_byte_q    <= 8'd0;
      ferr_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      status_q     <= status_d;
      need_q       <= need_d;
      idx_q        <= idx_d;
      data1_q      <= data1_d;
      msg_valid_q  <= msg_valid_d;
      msg_status_q <= msg_status_d;
      msg_data1_q  <= msg_data1_d;
      msg_data2_q  <= msg_data2_d;
      msg_len_q    <= msg_len_d;
      rt_valid_q   <= rt_valid_d;
      rt_byte_q    <= rt_byte_d;
      ferr_cnt_q   <= ferr_cnt_d;
    end
  end

  assign bus.msg_valid     = msg_valid_q;
  assign bus.msg_status    = msg_status_q;
  assign bus.msg_data1     = msg_data1_q;
  assign bus.msg_data2     = msg_data2_q;
  assign bus.msg_len       = msg_len_q;
  assign bus.rt_valid      = rt_valid_q;
  assign bus.rt_byte       = rt_byte_q;
  assign bus.sysex_active  = (state_q == StSysex);
  assign bus.frame_err_cnt = ferr_cnt_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser with hand-computed expectations.
module tb_midi_msg_parser;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   rt_cnt = 0;

  midi_msg_parser_if bus ();

  midi_msg_parser #(
    .RUNNING_STATUS_EN(1'b1),
    .VEL0_NOTEOFF     (1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Count realtime pulses; each lasts one full cycle so one negedge sees it.
  always @(negedge clk) if (bus.rt_valid === 1'b1) rt_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Present one byte for one cycle; returns at the negedge after the update.
  task automatic send(input logic [7:0] b, input logic ferr = 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = b;
    bus.byte_ferr  = ferr;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.byte_ferr  = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic expect_msg(input string tag, input logic [7:0] st, input logic [6:0] d1,
                            input logic [6:0] d2, input logic [1:0] len);
    check({tag, ".valid"}, 32'(bus.msg_valid), 32'd1);
    check({tag, ".status"}, 32'(bus.msg_status), 32'(st));
    check({tag, ".data1"}, 32'(bus.msg_data1), 32'(d1));
    check({tag, ".data2"}, 32'(bus.msg_data2), 32'(d2));
    check({tag, ".len"}, 32'(bus.msg_len), 32'(len));
  endtask

  task automatic expect_none(input string tag);
    check({tag, ".novalid"}, 32'(bus.msg_valid), 32'd0);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_ferr  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle();

    // Reset state
    check("rst.msg_valid", 32'(bus.msg_valid), 32'd0);
    check("rst.msg_status", 32'(bus.msg_status), 32'd0);
    check("rst.msg_len", 32'(bus.msg_len), 32'd0);
    check("rst.rt_valid", 32'(bus.rt_valid), 32'd0);
    check("rst.rt_byte", 32'(bus.rt_byte), 32'd0);
    check("rst.sysex", 32'(bus.sysex_active), 32'd0);
    check("rst.ferr_cnt", 32'(bus.frame_err_cnt), 32'd0);

    // 1: basic note-on
    send(8'h90); expect_none("t1.b1");
    send(8'h3C); expect_none("t1.b2");
    send(8'h64); expect_msg("t1", 8'h90, 7'h3C, 7'h64, 2'd2);
    idle();
    check("t1.pulse", 32'(bus.msg_valid), 32'd0);
    check("t1.hold", 32'(bus.msg_status), 32'h90);
    check("t1.rt_none", 32'(rt_cnt), 32'd0);

    // 2: running status with velocity-0 note-on becoming note-off
    send(8'h40); expect_none("t2.b1");
    send(8'h00); expect_msg("t2", 8'h80, 7'h40, 7'h00, 2'd2);
    send(8'h3C);
    send(8'h64); expect_msg("t2.held", 8'h90, 7'h3C, 7'h64, 2'd2);

    // 3: realtime interleaved mid-message
    send(8'h90);
    send(8'h3C);
    send(8'hF8);
    check("t3.rt_valid", 32'(bus.rt_valid), 32'd1);
    check("t3.rt_byte", 32'(bus.rt_byte), 32'hF8);
    expect_none("t3.rt");
    send(8'h64); expect_msg("t3", 8'h90, 7'h3C, 7'h64, 2'd2);
    check("t3.rt_off", 32'(bus.rt_valid), 32'd0);
    check("t3.rt_cnt", 32'(rt_cnt), 32'd1);

    // 4: SysEx swallowed, then program change
    send(8'hF0); check("t4.sx_on", 32'(bus.sysex_active), 32'd1);
    send(8'h7E); expect_none("t4.d1");
    send(8'h01); expect_none("t4.d2");
    check("t4.sx_mid", 32'(bus.sysex_active), 32'd1);
    send(8'hF7); check("t4.sx_off", 32'(bus.sysex_active), 32'd0);
    expect_none("t4.f7");
    send(8'hC5); expect_none("t4.c5");
    send(8'h10); expect_msg("t4", 8'hC5, 7'h10, 7'h00, 2'd1);

    // 5: framing error aborts partial data, status kept
    send(8'h90);
    send(8'h3C);
    send(8'h64, 1'b1); expect_none("t5.ferr");
    check("t5.cnt", 32'(bus.frame_err_cnt), 32'd1);
    send(8'h3C); expect_none("t5.b1");
    send(8'h64); expect_msg("t5", 8'h90, 7'h3C, 7'h64, 2'd2);

    // 6: reset mid-message
    send(8'h90);
    send(8'h3C);
    reset_n = 1'b0;
    idle();
    reset_n = 1'b1;
    send(8'h64); expect_none("t6.after");
    check("t6.status", 32'(bus.msg_status), 32'd0);
    check("t6.data1", 32'(bus.msg_data1), 32'd0);
    check("t6.ferr_cnt", 32'(bus.frame_err_cnt), 32'd0);
    check("t6.sysex", 32'(bus.sysex_active), 32'd0);
    send(8'h3C);
    send(8'h64); expect_none("t6.idle_data");

    // Tune request emits with no data; song position returns to idle after emit
    send(8'hF6); expect_msg("f6", 8'hF6, 7'h00, 7'h00, 2'd0);
    send(8'hF2);
    send(8'h01);
    send(8'h02); expect_msg("f2", 8'hF2, 7'h01, 7'h02, 2'd2);
    send(8'h03); expect_none("f2.idle");
    send(8'h04); expect_none("f2.idle2");
    send(8'hF3);
    send(8'h05); expect_msg("f3", 8'hF3, 7'h05, 7'h00, 2'd1);

    // Pitch bend, then a status mid-message aborts it
    send(8'hE2);
    send(8'h11);
    send(8'hB1);
    send(8'h07); expect_none("abort.b1");
    send(8'h7F); expect_msg("cc", 8'hB1, 7'h07, 7'h7F, 2'd2);

    // Frame error counter saturation (already at 0 after reset)
    for (int i = 0; i < 256; i++) send(8'h00, 1'b1);
    check("ferr.sat", 32'(bus.frame_err_cnt), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
